// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the keypad scanner
// and for blocks that consume its output (e.g. the press classifier).
//   state_t           : scanner FSM states
//   ROW_IDLE          : all rows released / all columns idle pattern
//   ROW_FIRST         : row drive pattern after reset (row 0 low)
//   onehot_low_index  : {valid, idx[1:0]} for a 4-bit active-low pattern
//   rotate_row        : next row drive pattern (rotate left by one)
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    // valid only when exactly one bit is low
    function automatic logic [2:0] onehot_low_index(input logic [3:0] pat);
        logic [2:0] res;
        res = 3'b000;
        case (pat)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] rotate_row(input logic [3:0] row);
        return {row[2:0], row[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad-side and key-output signals of the scanner.
//   col_in          : keypad columns, active-low, asynchronous
//   row_out         : row drive, active-low, one bit low
//   key_valid       : debounced key held
//   key_code        : {row_idx, col_idx} of the held key
//   key_press_pulse : one-clk strobe on key_valid rise
//                     (only with KEYPAD_PRESS_PULSE_EN defined)
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_valid;
    logic [3:0] key_code;
`ifdef KEYPAD_PRESS_PULSE_EN
    logic       key_press_pulse;

    modport master (input col_in, output row_out, output key_valid,
                    output key_code, output key_press_pulse);
    modport slave  (output col_in, input row_out, input key_valid,
                    input key_code, input key_press_pulse);
`else
    modport master (input col_in, output row_out, output key_valid,
                    output key_code);
    modport slave  (output col_in, input row_out, input key_valid,
                    input key_code);
`endif
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a one-clk scan tick
// every CLK_DIV clk cycles (counter 0..CLK_DIV-1, tick at the top).
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   o_tick  : one-cycle strobe when the counter is at CLK_DIV-1
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + W'(1);
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces press and release, and holds key_valid for the whole press.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   kp      : keypad_scanner_if.master (col_in, row_out, key_valid,
//             key_code, and key_press_pulse when KEYPAD_PRESS_PULSE_EN)
// Parameters: CLK_DIV (clk per scan tick), DEBOUNCE_TICKS (samples to
// accept a press or release).
//
// state    | meaning
// SCAN     | rotating rows, looking for a single low column
// DEBOUNCE | row held, counting matching samples of the candidate
// PRESSED  | key accepted, key_valid high
// RELEASE  | row held, key_valid still high, counting non-matching samples
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    keypad_scanner_if.master kp
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS);

    logic [3:0]    r_sync1, r_sync2;
    state_t        r_state, w_state_nx;
    logic [3:0]    r_row, w_row_nx;
    logic          r_valid, w_valid_nx;
    logic [3:0]    r_code, w_code_nx;
    logic [3:0]    r_cand, w_cand_nx;
    logic [DW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic          w_tick;
    logic [2:0]    w_col_dec, w_row_dec;
    logic          w_match;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= ROW_IDLE;
            r_sync2 <= ROW_IDLE;
        end else begin
            r_sync1 <= kp.col_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_col_dec = onehot_low_index(r_sync2);
    assign w_row_dec = onehot_low_index(r_row);
    // exact match: only the candidate column low on the held row
    assign w_match   = (r_sync2 == (ROW_IDLE & ~(4'b0001 << r_cand[1:0])));
    assign w_cnt_inc = r_cnt + DW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SCAN;
            r_row   <= ROW_FIRST;
            r_valid <= 1'b0;
            r_code  <= 4'h0;
            r_cand  <= 4'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_valid <= w_valid_nx;
            r_code  <= w_code_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_valid_nx = r_valid;
        w_code_nx  = r_code;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_col_dec[2] && w_row_dec[2]) begin
                        w_cand_nx = {w_row_dec[1:0], w_col_dec[1:0]};
                        // a single sample already satisfies a 1-tick debounce
                        if (DEBOUNCE_TICKS == 1) begin
                            w_valid_nx = 1'b1;
                            w_code_nx  = {w_row_dec[1:0], w_col_dec[1:0]};
                            w_cnt_nx   = '0;
                            w_state_nx = PRESSED;
                        end else begin
                            w_cnt_nx   = DW'(1);
                            w_state_nx = DEBOUNCE;
                        end
                    end else begin
                        w_row_nx = rotate_row(r_row);
                    end
                end
                DEBOUNCE: begin
                    if (w_match) begin
                        if (w_cnt_inc == DB_LAST) begin
                            w_valid_nx = 1'b1;
                            w_code_nx  = r_cand;
                            w_cnt_nx   = '0;
                            w_state_nx = PRESSED;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end else begin
                        w_row_nx   = rotate_row(r_row);
                        w_cnt_nx   = '0;
                        w_state_nx = SCAN;
                    end
                end
                PRESSED: begin
                    if (!w_match) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_valid_nx = 1'b0;
                            w_row_nx   = rotate_row(r_row);
                            w_cnt_nx   = '0;
                            w_state_nx = SCAN;
                        end else begin
                            w_cnt_nx   = DW'(1);
                            w_state_nx = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_match) begin
                        w_cnt_nx   = '0;
                        w_state_nx = PRESSED;
                    end else if (w_cnt_inc == DB_LAST) begin
                        w_valid_nx = 1'b0;
                        w_row_nx   = rotate_row(r_row);
                        w_cnt_nx   = '0;
                        w_state_nx = SCAN;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx = SCAN;
                end
            endcase
        end
    end

    assign kp.row_out   = r_row;
    assign kp.key_valid = r_valid;
    assign kp.key_code  = r_code;

`ifdef KEYPAD_PRESS_PULSE_EN
    logic r_pulse;

    // RELEASE keeps key_valid high, so bounce recovery cannot retrigger
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pulse <= 1'b0;
        else
            r_pulse <= w_valid_nx & ~r_valid;
    end

    assign kp.key_press_pulse = r_pulse;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with CLK_DIV=4, DEBOUNCE_TICKS=3. A keypad model
// pulls a column low while its row is driven and the key is in keys[].
// Optional key_press_pulse checks follow KEYPAD_PRESS_PULSE_EN.
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [15:0] keys;     // bit r*4+c = key at row r, column c pressed
    logic [3:0]  w_cols;
    int          n_assert;
    int          n_fail;
    int          pulse_cnt;

    keypad_scanner_if kp ();

    keypad_scanner #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp)
    );

    always_comb begin
        w_cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.row_out[r])
                    w_cols[c] = 1'b0;
    end
    assign kp.col_in = w_cols;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // returns at the first negedge where row_out newly equals target
    task automatic wait_row(input logic [3:0] target, output bit ok);
        int i;
        ok = 1'b0;
        for (i = 0; i < 64; i++) begin
            if (kp.row_out != target) break;
            @(negedge clk);
        end
        for (i = 0; i < 128; i++) begin
            @(negedge clk);
            if (kp.row_out == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        keys    = 16'h0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (kp.row_out !== 4'b1110) begin
            n_fail++; $display("FAIL reset_row: got %b want 1110", kp.row_out);
        end
        n_assert++;
        if (kp.key_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", kp.key_valid);
        end
        n_assert++;
        if (kp.key_code !== 4'h0) begin
            n_fail++; $display("FAIL reset_code: got %h want 0", kp.key_code);
        end
`ifdef KEYPAD_PRESS_PULSE_EN
        n_assert++;
        if (kp.key_press_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse: got %b want 0", kp.key_press_pulse);
        end
`endif
    endtask

    // reset released on a negedge; row advances at every 4th posedge
    task automatic test_idle;
        logic [3:0] one;
        logic [3:0] exp_row;
        one = 4'b0001;
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_row = 4'hF & ~(one << ((k / 4) % 4));
            n_assert++;
            if (kp.row_out !== exp_row) begin
                n_fail++; $display("FAIL idle_row: k=%0d got %b want %b", k, kp.row_out, exp_row);
            end
            n_assert++;
            if (kp.key_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_valid: k=%0d got %b want 0", k, kp.key_valid);
            end
        end
    endtask

    // key row2/col1; n counts negedges after row 1011 starts
    task automatic test_press;
        bit ok;
        keys = 16'h0;
        wait_row(4'b1110, ok);
        keys[9] = 1'b1;
        wait_row(4'b1011, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL press_wait_row: got timeout want row 1011");
        end
        pulse_cnt = 0;
        for (int n = 1; n <= 124; n++) begin
            @(negedge clk);
`ifdef KEYPAD_PRESS_PULSE_EN
            if (kp.key_press_pulse === 1'b1) pulse_cnt++;
            if (n == 12) begin
                n_assert++;
                if (kp.key_press_pulse !== 1'b1) begin
                    n_fail++; $display("FAIL press_pulse_edge: got %b want 1", kp.key_press_pulse);
                end
            end
`endif
            if (n < 12) begin
                n_assert++;
                if (kp.key_valid !== 1'b0) begin
                    n_fail++; $display("FAIL press_early_valid: n=%0d got %b want 0", n, kp.key_valid);
                end
            end else if (n < 124) begin
                n_assert++;
                if (kp.key_valid !== 1'b1 || kp.key_code !== 4'h9) begin
                    n_fail++;
                    $display("FAIL press_held: n=%0d got valid=%b code=%h want valid=1 code=9",
                             n, kp.key_valid, kp.key_code);
                end
            end
            if (n < 124) begin
                n_assert++;
                if (kp.row_out !== 4'b1011) begin
                    n_fail++; $display("FAIL press_row_hold: n=%0d got %b want 1011", n, kp.row_out);
                end
            end else begin
                n_assert++;
                if (kp.key_valid !== 1'b0 || kp.row_out !== 4'b0111 || kp.key_code !== 4'h9) begin
                    n_fail++;
                    $display("FAIL press_release: got valid=%b row=%b code=%h want valid=0 row=0111 code=9",
                             kp.key_valid, kp.row_out, kp.key_code);
                end
            end
            if (n == 112) keys = 16'h0;
        end
`ifdef KEYPAD_PRESS_PULSE_EN
        n_assert++;
        if (pulse_cnt != 1) begin
            n_fail++; $display("FAIL press_pulse_count: got %0d want 1", pulse_cnt);
        end
`endif
    endtask

    // row2/col1 low for two ticks only
    task automatic test_glitch;
        bit ok;
        keys = 16'h0;
        wait_row(4'b1110, ok);
        keys[9] = 1'b1;
        wait_row(4'b1011, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL glitch_wait_row: got timeout want row 1011");
        end
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            n_assert++;
            if (kp.key_valid !== 1'b0) begin
                n_fail++; $display("FAIL glitch_valid: n=%0d got %b want 0", n, kp.key_valid);
            end
            if (n == 11) begin
                n_assert++;
                if (kp.row_out !== 4'b1011) begin
                    n_fail++; $display("FAIL glitch_row_held: got %b want 1011", kp.row_out);
                end
            end
            if (n == 12) begin
                n_assert++;
                if (kp.row_out !== 4'b0111) begin
                    n_fail++; $display("FAIL glitch_row_resume: got %b want 0111", kp.row_out);
                end
            end
            if (n == 16) begin
                n_assert++;
                if (kp.row_out !== 4'b1110) begin
                    n_fail++; $display("FAIL glitch_row_next: got %b want 1110", kp.row_out);
                end
            end
            if (n == 7) keys = 16'h0;
        end
    endtask

    // one-tick release bounce, then clean release
    task automatic test_release_bounce;
        bit ok;
        keys = 16'h0;
        wait_row(4'b1110, ok);
        keys[9] = 1'b1;
        wait_row(4'b1011, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL bounce_wait_row: got timeout want row 1011");
        end
        pulse_cnt = 0;
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
`ifdef KEYPAD_PRESS_PULSE_EN
            if (kp.key_press_pulse === 1'b1) pulse_cnt++;
`endif
            if (n >= 12 && n < 52) begin
                n_assert++;
                if (kp.key_valid !== 1'b1) begin
                    n_fail++; $display("FAIL bounce_held: n=%0d got %b want 1", n, kp.key_valid);
                end
                n_assert++;
                if (kp.row_out !== 4'b1011) begin
                    n_fail++; $display("FAIL bounce_row: n=%0d got %b want 1011", n, kp.row_out);
                end
            end
            if (n == 52) begin
                n_assert++;
                if (kp.key_valid !== 1'b0 || kp.row_out !== 4'b0111) begin
                    n_fail++;
                    $display("FAIL bounce_release: got valid=%b row=%b want valid=0 row=0111",
                             kp.key_valid, kp.row_out);
                end
            end
            if (n == 16) keys[9] = 1'b0;
            if (n == 20) keys[9] = 1'b1;
            if (n == 40) keys = 16'h0;
        end
`ifdef KEYPAD_PRESS_PULSE_EN
        n_assert++;
        if (pulse_cnt != 1) begin
            n_fail++; $display("FAIL bounce_pulse_count: got %0d want 1", pulse_cnt);
        end
`endif
    endtask

    // two columns low on row0 must never be taken as a key
    task automatic test_ghost;
        bit ok;
        logic [3:0] one;
        logic [3:0] exp_row;
        one  = 4'b0001;
        keys = 16'h0;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        wait_row(4'b1101, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL ghost_wait_row: got timeout want row 1101");
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            exp_row = 4'hF & ~(one << ((1 + n / 4) % 4));
            n_assert++;
            if (kp.row_out !== exp_row || kp.key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ghost_scan: n=%0d got row=%b valid=%b want row=%b valid=0",
                         n, kp.row_out, kp.key_valid, exp_row);
            end
        end
        keys = 16'h0;
    endtask

    // row1/col3 held, then row2/col1 also pressed: code stays 7
    task automatic test_no_rollover;
        bit ok;
        keys = 16'h0;
        wait_row(4'b1110, ok);
        keys[7] = 1'b1;
        wait_row(4'b1101, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL roll_wait_row: got timeout want row 1101");
        end
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            if (n >= 12 && n < 52) begin
                n_assert++;
                if (kp.key_valid !== 1'b1 || kp.key_code !== 4'h7 || kp.row_out !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL roll_held: n=%0d got valid=%b code=%h row=%b want valid=1 code=7 row=1101",
                             n, kp.key_valid, kp.key_code, kp.row_out);
                end
            end
            if (n == 52) begin
                n_assert++;
                if (kp.key_valid !== 1'b0 || kp.key_code !== 4'h7 || kp.row_out !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL roll_release: got valid=%b code=%h row=%b want valid=0 code=7 row=1011",
                             kp.key_valid, kp.key_code, kp.row_out);
                end
                keys = 16'h0;
            end
            if (n == 16) keys[9] = 1'b1;
            if (n == 40) keys[7] = 1'b0;
        end
    endtask

    task automatic test_reset_pressed;
        bit ok;
        keys = 16'h0;
        wait_row(4'b1110, ok);
        keys[9] = 1'b1;
        wait_row(4'b1011, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL rstp_wait_row: got timeout want row 1011");
        end
        repeat (14) @(negedge clk);
        n_assert++;
        if (kp.key_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstp_pre_valid: got %b want 1", kp.key_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_assert++;
        if (kp.key_valid !== 1'b0 || kp.row_out !== 4'b1110 || kp.key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL rstp_async: got valid=%b row=%b code=%h want valid=0 row=1110 code=0",
                     kp.key_valid, kp.row_out, kp.key_code);
        end
`ifdef KEYPAD_PRESS_PULSE_EN
        n_assert++;
        if (kp.key_press_pulse !== 1'b0) begin
            n_fail++; $display("FAIL rstp_pulse: got %b want 0", kp.key_press_pulse);
        end
`endif
        keys = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        pulse_cnt = 0;
        keys      = 16'h0;
        reset_n   = 1'b0;
        test_reset;
        test_idle;
        test_press;
        test_glitch;
        test_release_bounce;
        test_ghost;
        test_no_rollover;
        test_reset_pressed;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
